// File: rtl/overlay_plotter.sv
// overlay_plotter
//   Frame-buffer writer for the game-over overlay. On an accepted start it
//   snapshots the COLS*ROWS bitmap and emits one VGA adapter write per cycle
//   in row-major order, then pulses done for one cycle.
//
//   Ports:
//     clock   in   system clock, rising edge
//     reset   in   synchronous, active-high
//     start   in   draw request, sampled only while idle
//     bitmap  in   overlay image, row r at bits [r*COLS+COLS-1 : r*COLS],
//                  MSB of each row is the leftmost pixel
//     x, y    out  screen coordinates of the current write
//     colour  out  pixel colour
//     plot    out  write strobe
//     busy    out  high during the draw and finish cycles
//     done    out  one-cycle pulse after the last pixel
//
//   Build option: define OVERLAY_TRANSPARENT_EN to plot only set pixels,
//   leaving the background untouched. Timing and scan order are unchanged.
module overlay_plotter #(
   parameter int unsigned COLS      = 100,
   parameter int unsigned ROWS      = 27,
   parameter int unsigned X_ORIGIN  = 30,
   parameter int unsigned Y_ORIGIN  = 46,
   parameter logic [2:0]  FG_COLOUR = 3'b111,
   parameter logic [2:0]  BG_COLOUR = 3'b000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [COLS*ROWS-1:0] bitmap,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           colour,
   output logic                 plot,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned NPIX = COLS * ROWS;
   localparam int unsigned IDXW = $clog2(NPIX);
   localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
   localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAW,
      ST_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [NPIX-1:0]   snapshot_q, snapshot_d;
   logic [6:0]        col_q, col_d;
   logic [4:0]        row_q, row_d;
   logic [7:0]        x_q, x_d;
   logic [6:0]        y_q, y_d;
   logic [2:0]        colour_q, colour_d;
   logic              plot_q, plot_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [IDXW-1:0]   pix_idx;
   logic              pix_bit;

   always_comb begin
      state_d    = state_q;
      snapshot_d = snapshot_q;
      col_d      = col_q;
      row_d      = row_q;
      x_d        = '0;
      y_d        = '0;
      colour_d   = '0;
      plot_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      // Column 0 is the row's MSB, so the bit index counts down across a row.
      pix_idx = IDXW'(32'(row_q) * COLS + (COLS - 1) - 32'(col_q));
      pix_bit = snapshot_q[pix_idx];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               snapshot_d = bitmap;
               col_d      = '0;
               row_d      = '0;
               state_d    = ST_DRAW;
            end
         end
         ST_DRAW: begin
            busy_d   = 1'b1;
            x_d      = 8'(X_ORIGIN + 32'(col_q));
            y_d      = 7'(Y_ORIGIN + 32'(row_q));
            colour_d = pix_bit ? FG_COLOUR : BG_COLOUR;
`ifdef OVERLAY_TRANSPARENT_EN
            plot_d   = pix_bit;
`else
            plot_d   = 1'b1;
`endif
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == ROW_LAST) begin
                  state_d = ST_FINISH;
               end else begin
                  row_d = row_q + 5'd1;
               end
            end else begin
               col_d = col_q + 7'd1;
            end
         end
         ST_FINISH: begin
            busy_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         snapshot_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
         plot_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snapshot_q <= snapshot_d;
         col_q      <= col_d;
         row_q      <= row_d;
         x_q        <= x_d;
         y_q        <= y_d;
         colour_q   <= colour_d;
         plot_q     <= plot_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign colour = colour_q;
   assign plot   = plot_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule
